// File: rtl/multdiv_pkg.sv
// multdiv_pkg: opcode and FSM state encodings shared by the mult/div unit
package multdiv_pkg;
  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV = 1'b1;
  typedef enum logic [1:0] {IDLE, RUN, DONE, ZERO} state_t;
endpackage

// File: rtl/multdiv_sign_fix.sv
// multdiv_sign_fix: negates a 2W-bit value whole (wide) or as independent W-bit halves (v/res, neg_hi, neg_lo)
module multdiv_sign_fix #(
  parameter int W = 32
) (
  input  logic [2*W-1:0] v,
  input  logic           wide,
  input  logic           neg_hi,
  input  logic           neg_lo,
  output logic [2*W-1:0] res
);
  logic [2*W-1:0] v_neg;
  logic [W-1:0] h, l;
  always_comb begin
    v_neg = -v;
    h = neg_hi ? -v[2*W-1:W] : v[2*W-1:W];
    l = neg_lo ? -v[W-1:0] : v[W-1:0];
    res = wide ? (neg_lo ? v_neg : v) : {h, l};
  end
endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative shift-add multiply / restoring divide into HI/LO (start/op/signed_op/a/b in; busy/done/div_zero/hi/lo out; signed mode via MULTDIV_SIGNED_EN)
module mult_div_unit
  import multdiv_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              op,
  input  logic              signed_op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic              div_zero,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);
  localparam int W = DATA_W;
  localparam int CNT_W = $clog2(DATA_W) + 1;
  state_t state, state_n;
  logic [CNT_W-1:0] cnt;
  logic op_r, accept, div0, last;
  logic [W-1:0] m;
  logic [W:0] sum, r_sh, diff;
  logic [2*W-1:0] prod, prod_n, ops_mag, res;
  assign div0 = op == OP_DIV && b == '0;
  assign accept = state == IDLE && start && !div0;
  assign last = cnt == CNT_W'(1);
  assign busy = state == RUN || state == DONE;
  assign done = state == DONE;
  assign div_zero = state == ZERO;
`ifdef MULTDIV_SIGNED_EN
  logic sa, sb;
  multdiv_sign_fix #(.W(W)) u_op (
    .v({a, b}),
    .wide(1'b0),
    .neg_hi(signed_op & a[W-1]),
    .neg_lo(signed_op & b[W-1]),
    .res(ops_mag)
  );
  multdiv_sign_fix #(.W(W)) u_res (
    .v(prod_n),
    .wide(op_r == OP_MULT),
    .neg_hi(sa),
    .neg_lo(sa ^ sb),
    .res(res)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      sa <= 1'b0;
      sb <= 1'b0;
    end else if (accept) begin
      sa <= signed_op & a[W-1];
      sb <= signed_op & b[W-1];
    end
  end
`else
  logic unused_signed;
  assign unused_signed = signed_op;
  assign ops_mag = {a, b};
  assign res = prod_n;
`endif
  always_comb begin
    sum = {1'b0, prod[2*W-1:W]} + {1'b0, m & {W{prod[0]}}};
    r_sh = prod[2*W-1:W-1];
    diff = r_sh - {1'b0, m};
    prod_n = op_r == OP_MULT ? {sum, prod[W-1:1]}
                             : {diff[W] ? r_sh[W-1:0] : diff[W-1:0], prod[W-2:0], ~diff[W]};
  end
  always_comb begin
    state_n = state == IDLE ? (start ? (div0 ? ZERO : RUN) : IDLE)
            : state == RUN  ? (last ? DONE : RUN)
            : IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      op_r <= OP_MULT;
      m <= '0;
      prod <= '0;
      hi <= '0;
      lo <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        cnt <= CNT_W'(DATA_W);
        op_r <= op;
        m <= ops_mag[W-1:0];
        prod <= {{W{1'b0}}, ops_mag[2*W-1:W]};
      end else if (state == RUN) begin
        cnt <= cnt - CNT_W'(1);
        prod <= prod_n;
        if (last) {hi, lo} <= res;
      end
    end
  end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed self-checking bench for mult_div_unit
module tb_mult_div_unit;
  import multdiv_pkg::*;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, op = 1'b0, signed_op = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic busy, done, div_zero;
  logic [31:0] hi, lo;
  int checks = 0, failures = 0;
  mult_div_unit #(.DATA_W(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .signed_op(signed_op),
    .a(a), .b(b), .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic run_op(input string tag, input logic o, input logic s, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] eh, input logic [31:0] el,
                        input int dup_at);
    int first_done, ndone;
    logic bad_busy, moved;
    logic [31:0] h0, l0;
    first_done = 0;
    ndone = 0;
    bad_busy = 1'b0;
    moved = 1'b0;
    h0 = hi;
    l0 = lo;
    op = o;
    signed_op = s;
    a = x;
    b = y;
    start = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        if (first_done == 0) first_done = n;
      end
      if (busy !== (n <= 33)) bad_busy = 1'b1;
      if (n < 33 && (hi !== h0 || lo !== l0)) moved = 1'b1;
      start = (n == dup_at);
      a = (n == dup_at) ? 32'd1 : 32'h5a5a5a5a;
      b = (n == dup_at) ? 32'd1 : 32'd3;
    end
    chk({tag, "_done_at"}, 32'(first_done), 32'd33);
    chk({tag, "_ndone"}, 32'(ndone), 32'd1);
    chk({tag, "_busy"}, 32'(bad_busy), 32'd0);
    chk({tag, "_stable"}, 32'(moved), 32'd0);
    chk({tag, "_hi"}, hi, eh);
    chk({tag, "_lo"}, lo, el);
  endtask
  initial begin
    int nd;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_dz", 32'(div_zero), 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    run_op("mulu_7x6", OP_MULT, 1'b0, 32'd7, 32'd6, 32'h0, 32'h2a, 0);
    run_op("mulu_max", OP_MULT, 1'b0, 32'hffffffff, 32'hffffffff, 32'hfffffffe, 32'h1, 0);
    run_op("divu_100_7", OP_DIV, 1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 0);
    op = OP_DIV;
    a = 32'd55;
    b = 32'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("dz_pulse", 32'(div_zero), 32'd1);
    chk("dz_busy", 32'(busy), 32'd0);
    nd = 0;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      if (done || div_zero) nd++;
    end
    chk("dz_quiet", 32'(nd), 32'd0);
    chk("dz_hi", hi, 32'd2);
    chk("dz_lo", lo, 32'd14);
`ifdef MULTDIV_SIGNED_EN
    run_op("divs_m7_2", OP_DIV, 1'b1, 32'hfffffff9, 32'd2, 32'hffffffff, 32'hfffffffd, 0);
    run_op("muls_m3_5", OP_MULT, 1'b1, 32'hfffffffd, 32'd5, 32'hffffffff, 32'hfffffff1, 0);
    run_op("divs_min_m1", OP_DIV, 1'b1, 32'h80000000, 32'hffffffff, 32'h0, 32'h80000000, 0);
    run_op("divs_7_m2", OP_DIV, 1'b1, 32'd7, 32'hfffffffe, 32'd1, 32'hfffffffd, 0);
`else
    run_op("divs_ign", OP_DIV, 1'b1, 32'hfffffff9, 32'd2, 32'h1, 32'h7ffffffc, 0);
    run_op("muls_ign", OP_MULT, 1'b1, 32'hfffffffd, 32'd5, 32'h4, 32'hfffffff1, 0);
    run_op("divs_min_ign", OP_DIV, 1'b1, 32'h80000000, 32'hffffffff, 32'h80000000, 32'h0, 0);
`endif
    run_op("dup_start", OP_MULT, 1'b0, 32'd123, 32'd1000, 32'h0, 32'h0001e078, 5);
    op = OP_MULT;
    signed_op = 1'b0;
    a = 32'd7;
    b = 32'd6;
    start = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      start = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    reset = 1'b0;
    nd = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("abort_nodone", 32'(nd), 32'd0);
    run_op("divu_after_rst", OP_DIV, 1'b0, 32'hffffffff, 32'h10, 32'hf, 32'h0fffffff, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Parametrised iterative multiply/divide unit with HI/LO result registers for the multicycle MIPS datapath.
- Driven by the control FSM through a start/busy/done handshake.
- Results are read via MFHI/MFLO paths into the write-data mux.
- Replaces the single-cycle multiply path with a shared shift-add / restoring-divide engine.
- Flags divide-by-zero for the exception (EPC) path.

Parameters:
- DATA_W, 32, operand and HI/LO width; must be >= 2.
- CNT_W, $clog2(DATA_W)+1, iteration counter width (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle request; sampled only in IDLE
- op  input  1  0 = multiply, 1 = divide
- signed_op  input  1  1 = signed (mult/div), 0 = unsigned (multu/divu)
- a  input  DATA_W  multiplicand / dividend (from A register)
- b  input  DATA_W  multiplier / divisor (from B register)
- busy  output  1  high while an operation is in flight (RUN and DONE)
- done  output  1  one-cycle pulse; HI/LO hold the new result in this cycle
- div_zero  output  1  one-cycle pulse; divide with b == 0
- hi  output  DATA_W  HI register
- lo  output  DATA_W  LO register

Behaviour:
- Reset: state = IDLE; busy = 0, done = 0, div_zero = 0, hi = 0, lo = 0, counter = 0.
- Reset mid-operation aborts the operation; no done is produced.
- States:
  - IDLE: start = 1 and op = 1 and b == 0 -> ZERO.
  - IDLE: any other start = 1 -> RUN. Operands are latched and the counter loaded with DATA_W.
  - RUN: one iteration per cycle, counter decrements; counter reaches 1 -> DONE.
  - DONE: done = 1 for one cycle -> IDLE.
  - ZERO: div_zero = 1 for one cycle, HI/LO unchanged -> IDLE.
- Latency: start accepted at cycle T -> done = 1 at T+DATA_W+1 (T+33 for DATA_W = 32). div_zero = 1 at T+1.
- busy = 1 from T+1 through the done cycle inclusive. busy = 0 in ZERO.
- A new start may be accepted the cycle after done.
- start while not in IDLE is ignored, with no queuing.
- Multiply: shift-add over magnitudes, 2*DATA_W-bit product. HI = product[2*DATA_W-1:DATA_W], LO = product[DATA_W-1:0].
- Divide: restoring shift-subtract. LO = quotient, HI = remainder.
- Signed mode:
  - Magnitudes are taken at accept; signs are applied when DONE is entered.
  - Product is negated if the operand signs differ.
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
  - MIN / -1 wraps: LO = MIN, HI = 0. No flag is raised.
- HI/LO change only on the edge entering DONE or on reset. They are stable at all other times, including while busy.
- Operand inputs may change after the accept cycle without affecting the result.

Optional Feature:
- MULTDIV_SIGNED_EN defined: signed_op is honoured as above.
- Not defined: signed_op is ignored and all operations are unsigned. The sign-fix logic is not synthesised; the port remains present.

Decomposition:
- Package multdiv_pkg holds:
  - OP_MULT = 1'b0, OP_DIV = 1'b1
  - state encoding IDLE / RUN / DONE / ZERO (2 bits)
- One sub-module is natural: multdiv_sign_fix (combinational magnitude/negate helper). It is instantiated twice, at the operand side and the result side.

Test Plan:
- Unsigned mult, a = 7, b = 6 -> done at T+33, HI = 0x00000000, LO = 0x0000002A. busy high T+1..T+33.
- Unsigned mult, a = b = 0xFFFFFFFF -> HI = 0xFFFFFFFE, LO = 0x00000001.
- Unsigned div, a = 100, b = 7 -> LO = 14, HI = 2. Repeat with b = 0 -> div_zero pulse at T+1, no done, HI/LO retain 14/2.
- Signed div (MULTDIV_SIGNED_EN), a = -7, b = 2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
- Signed mult, a = -3, b = 5 -> HI = 0xFFFFFFFF, LO = 0xFFFFFFF1.
- Signed div 0x80000000 / 0xFFFFFFFF -> LO = 0x80000000, HI = 0.
- Second start at T+5 while busy -> ignored; the first result is unaltered and exactly one done is produced.
- reset asserted at T+10 of a multiply -> next cycle busy = 0, hi = lo = 0, and done never pulses.
